// File: rtl/div_issue_arbiter_pkg.sv
// Shared types for the divider issue path: decoded div control and fixed field widths.
package div_issue_arbiter_pkg;

  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic is_signed;
    logic is_extended;
    logic is_word;
    logic oe;
    logic rc;
  } div_decode_t;

endpackage

// File: rtl/div_issue_arbiter.sv
// Round-robin arbiter feeding one div_unit from NUM_REQ reservation slots through a
// one-entry issue register, with a credit counter limiting granted-but-uncompleted ops.
module div_issue_arbiter
  import div_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned RS_ID_WIDTH  = 5,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ-1:0][RS_ID_WIDTH-1:0]    req_rs_id,
  input  logic [NUM_REQ-1:0][GPR_ADDR_W-1:0]     req_result_reg_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]         req_op1,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]         req_op2,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]         req_xer,
  input  div_decode_t [NUM_REQ-1:0]              req_control,
  output logic                                   div_valid,
  input  logic                                   div_ready,
  output logic [RS_ID_WIDTH-1:0]                 div_rs_id,
  output logic [GPR_ADDR_W-1:0]                  div_result_reg_addr,
  output logic [DATA_W-1:0]                      div_op1,
  output logic [DATA_W-1:0]                      div_op2,
  output logic [DATA_W-1:0]                      div_xer,
  output div_decode_t                            div_control,
  input  logic                                   done_valid,
  input  logic                                   done_ready,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]      inflight_count,
  output logic                                   busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic                   issue;
  logic                   done;
  logic                   done_ok;
  logic                   drop;
  logic                   slot_free;
  logic                   credit_ok;
  logic                   found;
  logic                   grant;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       pick;
  logic [PTR_W-1:0]       scan;
  logic [PTR_W-1:0]       rr_ptr_nxt;
  logic                   valid_nxt;
  logic [CNT_W-1:0]       count_nxt;
  logic [RS_ID_WIDTH-1:0] rs_id_nxt;
  logic [GPR_ADDR_W-1:0]  reg_addr_nxt;
  logic [DATA_W-1:0]      op1_nxt;
  logic [DATA_W-1:0]      op2_nxt;
  logic [DATA_W-1:0]      xer_nxt;
  div_decode_t            control_nxt;
  int                     cnt;

  assign issue     = div_valid & div_ready;
  assign done      = done_valid & done_ready;
  assign done_ok   = done & (inflight_count != '0);
  assign drop      = flush & div_valid & ~issue;
  assign slot_free = ~div_valid | issue;
  assign credit_ok = (inflight_count < CNT_W'(MAX_INFLIGHT)) | done;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin : arbitrate
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
    grant     = found & slot_free & credit_ok & ~flush;
    req_ready = grant ? (NUM_REQ'(1) << pick) : '0;
  end

  // Next state for pointer, issue register and credit counter.
  always_comb begin : next_state
    rr_ptr_nxt   = rr_ptr;
    valid_nxt    = div_valid;
    rs_id_nxt    = div_rs_id;
    reg_addr_nxt = div_result_reg_addr;
    op1_nxt      = div_op1;
    op2_nxt      = div_op2;
    xer_nxt      = div_xer;
    control_nxt  = div_control;
    cnt          = int'(inflight_count);

    if (grant) begin
      valid_nxt    = 1'b1;
      rs_id_nxt    = req_rs_id[pick];
      reg_addr_nxt = req_result_reg_addr[pick];
      op1_nxt      = req_op1[pick];
      op2_nxt      = req_op2[pick];
      xer_nxt      = req_xer[pick];
      control_nxt  = req_control[pick];
      rr_ptr_nxt   = (32'(pick) == NUM_REQ - 1) ? '0 : pick + PTR_W'(1);
    end else if (issue || drop) begin
      valid_nxt = 1'b0;
    end

    if (grant)   cnt = cnt + 1;
    if (done_ok) cnt = cnt - 1;
    if (drop)    cnt = cnt - 1;
    if (cnt < 0) cnt = 0;
    count_nxt = CNT_W'(cnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr              <= '0;
      div_valid           <= 1'b0;
      div_rs_id           <= '0;
      div_result_reg_addr <= '0;
      div_op1             <= '0;
      div_op2             <= '0;
      div_xer             <= '0;
      div_control         <= '0;
      inflight_count      <= '0;
      busy                <= 1'b0;
    end else begin
      rr_ptr              <= rr_ptr_nxt;
      div_valid           <= valid_nxt;
      div_rs_id           <= rs_id_nxt;
      div_result_reg_addr <= reg_addr_nxt;
      div_op1             <= op1_nxt;
      div_op2             <= op2_nxt;
      div_xer             <= xer_nxt;
      div_control         <= control_nxt;
      inflight_count      <= count_nxt;
      busy                <= (count_nxt != '0);
    end
  end

  // A completion with nothing outstanding means the div_unit and this counter disagree.
  assert property (@(posedge clk) disable iff (!rst) done |-> (inflight_count != '0));

endmodule

// File: tb/tb_div_issue_arbiter.sv
// Self-checking bench for div_issue_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, held op and credit usage.
module tb_div_issue_arbiter;
  import div_issue_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int MAXF = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N-1:0][4:0]  req_rs_id;
  logic [N-1:0][4:0]  req_result_reg_addr;
  logic [N-1:0][31:0] req_op1;
  logic [N-1:0][31:0] req_op2;
  logic [N-1:0][31:0] req_xer;
  div_decode_t [N-1:0] req_control;
  logic             div_valid;
  logic             div_ready;
  logic [4:0]       div_rs_id;
  logic [4:0]       div_result_reg_addr;
  logic [31:0]      div_op1;
  logic [31:0]      div_op2;
  logic [31:0]      div_xer;
  div_decode_t      div_control;
  logic             done_valid;
  logic             done_ready;
  logic [2:0]       inflight_count;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  div_issue_arbiter #(.NUM_REQ(N), .RS_ID_WIDTH(5), .MAX_INFLIGHT(MAXF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs_id(req_rs_id),
    .req_result_reg_addr(req_result_reg_addr), .req_op1(req_op1), .req_op2(req_op2),
    .req_xer(req_xer), .req_control(req_control),
    .div_valid(div_valid), .div_ready(div_ready), .div_rs_id(div_rs_id),
    .div_result_reg_addr(div_result_reg_addr), .div_op1(div_op1), .div_op2(div_op2),
    .div_xer(div_xer), .div_control(div_control),
    .done_valid(done_valid), .done_ready(done_ready),
    .inflight_count(inflight_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      req_rs_id[i]           = 5'($urandom);
      req_result_reg_addr[i] = 5'($urandom);
      req_op1[i]             = $urandom;
      req_op2[i]             = $urandom;
      req_xer[i]             = $urandom;
      req_control[i]         = div_decode_t'(5'($urandom));
    end
  endtask

  task automatic idle_inputs();
    flush      = 1'b0;
    req_valid  = '0;
    div_ready  = 1'b0;
    done_valid = 1'b0;
    done_ready = 1'b0;
    randomize_fields();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    n_checks++;
    if (div_valid !== 1'b0 || inflight_count !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: div_valid=%0b count=%0d busy=%0b expected 0 0 0", div_valid, inflight_count, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
    end
    n_checks++;
    if (div_op1 !== 32'd0 || div_op2 !== 32'd0 || div_rs_id !== 5'd0 || div_xer !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: op1=%h op2=%h rs_id=%h xer=%h expected all zero", div_op1, div_op2, div_rs_id, div_xer);
    end
    // Hold req2's op, then reset while held.
    req_valid = 4'b0100;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_pre_grant: got %b expected 0100", req_ready);
    end
    next_cycle();
    req_valid = '0;
    n_checks++;
    if (div_valid !== 1'b1 || inflight_count !== 3'd1 || div_op1 !== req_op1[2]) begin
      n_fail++;
      $display("FAIL reset_hold: div_valid=%0b count=%0d op1=%h expected 1 1 %h", div_valid, inflight_count, div_op1, req_op1[2]);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (div_valid !== 1'b0 || inflight_count !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: div_valid=%0b count=%0d busy=%0b expected 0 0 0", div_valid, inflight_count, busy);
    end
    next_cycle();
    rst = 1'b1;
    req_valid = 4'b1111;
    div_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_rr_ptr: got %b expected 0001", req_ready);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_ready;
    do_reset();
    req_valid  = 4'b1111;
    div_ready  = 1'b1;
    done_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      done_valid = (c > 0);
      exp_ready  = 4'(1 << (c % N));
      #1;
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL fairness_grant%0d: got %b expected %b", c, req_ready, exp_ready);
      end
      next_cycle();
      n_checks++;
      if (div_valid !== 1'b1 || div_rs_id !== req_rs_id[c % N] || inflight_count !== 3'd1) begin
        n_fail++;
        $display("FAIL fairness_held%0d: valid=%0b rs_id=%0d count=%0d expected 1 %0d 1", c, div_valid, div_rs_id, inflight_count, req_rs_id[c % N]);
      end
    end
    done_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [4:0]  exp_id;
    logic [31:0] exp_xer;
    do_reset();
    req_valid  = 4'b0010;
    req_op1[1] = 32'd100;
    req_op2[1] = 32'd7;
    exp_id     = req_rs_id[1];
    exp_xer    = req_xer[1];
    next_cycle();
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      randomize_fields();
      #1;
      n_checks++;
      if (req_ready !== 4'b0000 || div_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: req_ready=%b div_valid=%0b expected 0000 1", c, req_ready, div_valid);
      end
      n_checks++;
      if (div_op1 !== 32'd100 || div_op2 !== 32'd7 || div_rs_id !== exp_id || div_xer !== exp_xer) begin
        n_fail++;
        $display("FAIL backpressure_stable%0d: op1=%0d op2=%0d rs_id=%0d expected 100 7 %0d", c, div_op1, div_op2, div_rs_id, exp_id);
      end
      next_cycle();
    end
    div_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL backpressure_release: got %b expected 0100", req_ready);
    end
    exp_xer = req_op1[2];
    next_cycle();
    n_checks++;
    if (div_op1 !== exp_xer || inflight_count !== 3'd2) begin
      n_fail++;
      $display("FAIL backpressure_next: op1=%h count=%0d expected %h 2", div_op1, inflight_count, exp_xer);
    end
    div_ready = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_credit();
    logic [3:0] exp_ready;
    do_reset();
    req_valid = 4'b1111;
    div_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exp_ready = (c < MAXF) ? 4'(1 << c) : 4'b0000;
      #1;
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL credit_grant%0d: got %b expected %b", c, req_ready, exp_ready);
      end
      next_cycle();
    end
    n_checks++;
    if (inflight_count !== 3'd4 || busy !== 1'b1 || div_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_full: count=%0d busy=%0b div_valid=%0b expected 4 1 0", inflight_count, busy, div_valid);
    end
    done_valid = 1'b1;
    done_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL credit_done_grant: got %b expected 0001", req_ready);
    end
    next_cycle();
    done_valid = 1'b0;
    n_checks++;
    if (inflight_count !== 3'd4 || div_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_done_count: count=%0d div_valid=%0b expected 4 1", inflight_count, div_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    req_valid  = 4'b0010;
    req_op1[1] = 32'd100;
    req_op2[1] = 32'd7;
    next_cycle();
    req_valid = '0;
    n_checks++;
    if (div_valid !== 1'b1 || inflight_count !== 3'd1 || div_op1 !== 32'd100 || div_op2 !== 32'd7) begin
      n_fail++;
      $display("FAIL flush_setup: valid=%0b count=%0d op1=%0d op2=%0d expected 1 1 100 7", div_valid, inflight_count, div_op1, div_op2);
    end
    flush     = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_no_grant: got %b expected 0000", req_ready);
    end
    next_cycle();
    flush = 1'b0;
    n_checks++;
    if (div_valid !== 1'b0 || inflight_count !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop: valid=%0b count=%0d busy=%0b expected 0 0 0", div_valid, inflight_count, busy);
    end
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL flush_after: got %b expected 0100", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    logic [3:0] vals [3];
    logic [3:0] exps [3];
    vals[0] = 4'b1001; vals[1] = 4'b1001; vals[2] = 4'b0011;
    exps[0] = 4'b1000; exps[1] = 4'b0001; exps[2] = 4'b0010;
    do_reset();
    div_ready = 1'b1;
    req_valid = 4'b0100;
    next_cycle();
    done_valid = 1'b1;
    done_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req_valid = vals[c];
      #1;
      n_checks++;
      if (req_ready !== exps[c]) begin
        n_fail++;
        $display("FAIL wrap_grant%0d: got %b expected %b", c, req_ready, exps[c]);
      end
      next_cycle();
    end
    done_valid = 1'b0;
    req_valid  = '0;
  endtask

  task automatic test_random();
    bit          m_valid;
    int          m_ptr;
    int          m_count;
    logic [4:0]  m_id;
    logic [4:0]  m_addr;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [31:0] m_xer;
    div_decode_t m_ctl;
    int          best;
    int          bestd;
    int          d;
    bit          can;
    bit          dn;
    logic [3:0]  exp_ready;
    do_reset();
    m_valid = 0; m_ptr = 0; m_count = 0;
    m_id = '0; m_addr = '0; m_op1 = '0; m_op2 = '0; m_xer = '0; m_ctl = '0;
    for (int c = 0; c < 400; c++) begin
      randomize_fields();
      req_valid  = 4'($urandom);
      div_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 9) == 0);
      done_ready = ($urandom_range(0, 9) < 8);
      // Only ops already handed to the div_unit can complete.
      done_valid = ($urandom_range(0, 1) == 1) && (m_count - int'(m_valid) > 0);
      dn  = done_valid && done_ready;
      can = !flush && (!m_valid || div_ready) && (m_count < MAXF || dn);
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_ptr + N) % N;
        if (req_valid[i] && d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
      if (!can) best = -1;
      exp_ready = (best >= 0) ? 4'(1 << best) : 4'b0000;
      #1;
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL random_grant c=%0d: got %b expected %b", c, req_ready, exp_ready);
      end
      if (flush && m_valid && !div_ready) m_count--;
      if (dn) m_count--;
      if (best >= 0) begin
        m_count++;
        m_id = req_rs_id[best]; m_addr = req_result_reg_addr[best];
        m_op1 = req_op1[best]; m_op2 = req_op2[best]; m_xer = req_xer[best];
        m_ctl = req_control[best];
        m_ptr = (best + 1) % N;
      end
      m_valid = (best >= 0) ? 1'b1 : ((m_valid && div_ready) || flush) ? 1'b0 : m_valid;
      next_cycle();
      n_checks++;
      if (div_valid !== m_valid || int'(inflight_count) != m_count || busy !== (m_count != 0)) begin
        n_fail++;
        $display("FAIL random_state c=%0d: valid=%0b count=%0d busy=%0b expected %0b %0d %0b", c, div_valid, inflight_count, busy, m_valid, m_count, (m_count != 0));
      end
      if (m_valid) begin
        n_checks++;
        if (div_rs_id !== m_id || div_result_reg_addr !== m_addr || div_op1 !== m_op1 ||
            div_op2 !== m_op2 || div_xer !== m_xer || div_control !== m_ctl) begin
          n_fail++;
          $display("FAIL random_fields c=%0d: rs_id=%0d addr=%0d op1=%h op2=%h expected %0d %0d %h %h", c, div_rs_id, div_result_reg_addr, div_op1, div_op2, m_id, m_addr, m_op1, m_op2);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_backpressure();
    test_credit();
    test_flush();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
